// File: rtl/bp_mem_cmd_router_if.sv
// Bus bundle for bp_mem_cmd_router: UCE command/response channels plus CLINT, I/O and memory target ports.
// The router uses the slave modport; the UCE/target environment uses master.
interface bp_mem_cmd_router_if #(
  parameter int num_chan_p = 2,
  parameter int W          = 64
);
  logic [num_chan_p*W-1:0] cmd_i;
  logic [num_chan_p-1:0]   cmd_v_i;
  logic [num_chan_p-1:0]   cmd_ready_o;
  logic [num_chan_p*W-1:0] resp_o;
  logic [num_chan_p-1:0]   resp_v_o;
  logic [num_chan_p-1:0]   resp_yumi_i;

  logic [W-1:0] clint_cmd_o,  io_cmd_o,  mem_cmd_o;
  logic         clint_cmd_v_o, io_cmd_v_o, mem_cmd_v_o;
  logic         clint_cmd_ready_i, io_cmd_ready_i, mem_cmd_ready_i;
  logic [W-1:0] clint_resp_i, io_resp_i, mem_resp_i;
  logic         clint_resp_v_i, io_resp_v_i, mem_resp_v_i;
  logic         clint_resp_yumi_o, io_resp_yumi_o, mem_resp_yumi_o;
  logic         error_o;

  modport slave (
    input  cmd_i, cmd_v_i, resp_yumi_i,
    input  clint_cmd_ready_i, io_cmd_ready_i, mem_cmd_ready_i,
    input  clint_resp_i, io_resp_i, mem_resp_i,
    input  clint_resp_v_i, io_resp_v_i, mem_resp_v_i,
    output cmd_ready_o, resp_o, resp_v_o,
    output clint_cmd_o, io_cmd_o, mem_cmd_o,
    output clint_cmd_v_o, io_cmd_v_o, mem_cmd_v_o,
    output clint_resp_yumi_o, io_resp_yumi_o, mem_resp_yumi_o,
    output error_o
  );

  modport master (
    output cmd_i, cmd_v_i, resp_yumi_i,
    output clint_cmd_ready_i, io_cmd_ready_i, mem_cmd_ready_i,
    output clint_resp_i, io_resp_i, mem_resp_i,
    output clint_resp_v_i, io_resp_v_i, mem_resp_v_i,
    input  cmd_ready_o, resp_o, resp_v_o,
    input  clint_cmd_o, io_cmd_o, mem_cmd_o,
    input  clint_cmd_v_o, io_cmd_v_o, mem_cmd_v_o,
    input  clint_resp_yumi_o, io_resp_yumi_o, mem_resp_yumi_o,
    input  error_o
  );
endinterface

// File: rtl/bp_mem_cmd_router.sv
// N-channel UCE command router: per-channel FIFO, round-robin dispatch to CLINT/IO/mem, credit-limited, lce_id response return.
// Optional per-channel grant/stall counters when BP_MEM_CMD_ROUTER_STATS_EN is defined.
module bp_mem_cmd_router #(
  parameter int         num_chan_p           = 2,
  parameter int         fifo_els_p           = 2,
  parameter int         max_outstanding_p    = 4,
  parameter int         cce_mem_msg_width_lp = 64,
  parameter int         addr_width_p         = 40,
  parameter int         lce_id_lsb_p         = 40,
  parameter int         lce_id_width_p       = 4,
  parameter logic [3:0] host_dev_gp          = 4'd1,
  parameter logic [3:0] clint_dev_gp         = 4'd3
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  bp_mem_cmd_router_if.slave      bus
`ifdef BP_MEM_CMD_ROUTER_STATS_EN
  ,
  output logic [num_chan_p*32-1:0] stat_cmd_count_o,
  output logic [num_chan_p*32-1:0] stat_stall_count_o
`endif
);
  localparam int W  = cce_mem_msg_width_lp;
  localparam int CW = (num_chan_p > 1) ? $clog2(num_chan_p) : 1;
  localparam int FW = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
  localparam int NW = $clog2(fifo_els_p + 1);
  localparam int OW = $clog2(max_outstanding_p + 1);
  localparam logic [1:0] TGT_MEM   = 2'd0;
  localparam logic [1:0] TGT_IO    = 2'd1;
  localparam logic [1:0] TGT_CLINT = 2'd2;

  // Async assert, synchronous release; everything else resets from w_rst_n.
  logic [1:0] r_rst_sync;
  logic       w_rst_n;
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) r_rst_sync <= 2'b00;
    else            r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  logic [W-1:0]  r_mem   [num_chan_p][fifo_els_p];
  logic [FW-1:0] r_rd    [num_chan_p];
  logic [FW-1:0] r_wr    [num_chan_p];
  logic [NW-1:0] r_cnt   [num_chan_p];
  logic [OW-1:0] r_outst [num_chan_p];
  logic [CW-1:0] r_ptr;
  logic          r_err;

  logic [W-1:0]          w_head [num_chan_p];
  logic [1:0]            w_tgt  [num_chan_p];
  logic [1:0]            w_sel  [num_chan_p];
  logic [num_chan_p-1:0] w_hv, w_enq, w_deq, w_elig, w_dec;
  logic                  w_gnt_v;
  logic [CW-1:0]         w_gnt;

  for (genvar gc = 0; gc < num_chan_p; gc++) begin : g_chan
    logic       w_local;
    logic [3:0] w_dev;
    logic       w_rdy;
    assign w_head[gc] = r_mem[gc][r_rd[gc]];
    assign w_hv[gc]   = (r_cnt[gc] != '0);
    assign bus.cmd_ready_o[gc] = w_rst_n && (r_cnt[gc] != NW'(fifo_els_p));
    assign w_enq[gc]  = bus.cmd_v_i[gc] && bus.cmd_ready_o[gc];
    assign w_local    = (w_head[gc][addr_width_p-1:31] == '0);
    assign w_dev      = w_head[gc][23:20];
    assign w_tgt[gc]  = (w_local && w_dev == host_dev_gp)  ? TGT_IO :
                        (w_local && w_dev == clint_dev_gp) ? TGT_CLINT : TGT_MEM;
    assign w_rdy      = (w_tgt[gc] == TGT_IO)    ? bus.io_cmd_ready_i :
                        (w_tgt[gc] == TGT_CLINT) ? bus.clint_cmd_ready_i : bus.mem_cmd_ready_i;
    assign w_elig[gc] = w_hv[gc] && w_rdy && (r_outst[gc] < OW'(max_outstanding_p));
    assign w_deq[gc]  = w_gnt_v && (w_gnt == CW'(gc));
    assign w_dec[gc]  = bus.resp_v_o[gc] && bus.resp_yumi_i[gc] && (r_outst[gc] != '0);
  end

  always_comb begin
    int idx;
    idx     = 0;
    w_gnt_v = 1'b0;
    w_gnt   = '0;
    for (int k = 0; k < num_chan_p; k++) begin
      idx = (int'(r_ptr) + k) % num_chan_p;
      if (!w_gnt_v && w_elig[idx]) begin
        w_gnt_v = 1'b1;
        w_gnt   = CW'(idx);
      end
    end
  end

  assign bus.clint_cmd_o   = w_head[w_gnt];
  assign bus.io_cmd_o      = w_head[w_gnt];
  assign bus.mem_cmd_o     = w_head[w_gnt];
  assign bus.clint_cmd_v_o = w_gnt_v && (w_tgt[w_gnt] == TGT_CLINT);
  assign bus.io_cmd_v_o    = w_gnt_v && (w_tgt[w_gnt] == TGT_IO);
  assign bus.mem_cmd_v_o   = w_gnt_v && (w_tgt[w_gnt] == TGT_MEM);

  // Source index 0 is highest priority: clint, then io, then mem.
  logic [W-1:0]              w_src_msg [3];
  logic [lce_id_width_p-1:0] w_src_id  [3];
  logic [2:0]                w_src_v, w_src_oor, w_src_yumi;
  assign w_src_msg[0] = bus.clint_resp_i;
  assign w_src_msg[1] = bus.io_resp_i;
  assign w_src_msg[2] = bus.mem_resp_i;
  assign w_src_v      = {bus.mem_resp_v_i, bus.io_resp_v_i, bus.clint_resp_v_i};
  for (genvar gs = 0; gs < 3; gs++) begin : g_src
    assign w_src_id[gs]  = w_src_msg[gs][lce_id_lsb_p +: lce_id_width_p];
    assign w_src_oor[gs] = (int'(w_src_id[gs]) >= num_chan_p);
  end

  always_comb begin
    bus.resp_o   = '0;
    bus.resp_v_o = '0;
    for (int c = 0; c < num_chan_p; c++) begin
      w_sel[c] = 2'd0;
      for (int s = 2; s >= 0; s--) begin
        if (w_rst_n && w_src_v[s] && !w_src_oor[s] && int'(w_src_id[s]) == c) begin
          bus.resp_v_o[c]       = 1'b1;
          bus.resp_o[c*W +: W]  = w_src_msg[s];
          w_sel[c]              = 2'(s);
        end
      end
    end
  end

  always_comb begin
    w_src_yumi = '0;
    for (int s = 0; s < 3; s++) begin
      if (w_rst_n && w_src_v[s] && w_src_oor[s]) w_src_yumi[s] = 1'b1;
      for (int c = 0; c < num_chan_p; c++) begin
        if (bus.resp_v_o[c] && bus.resp_yumi_i[c] && w_sel[c] == 2'(s)) w_src_yumi[s] = 1'b1;
      end
    end
  end

  assign bus.clint_resp_yumi_o = w_src_yumi[0];
  assign bus.io_resp_yumi_o    = w_src_yumi[1];
  assign bus.mem_resp_yumi_o   = w_src_yumi[2];
  assign bus.error_o           = r_err;

  always_ff @(posedge clk_i) begin
    for (int c = 0; c < num_chan_p; c++) begin
      if (w_enq[c]) r_mem[c][r_wr[c]] <= bus.cmd_i[c*W +: W];
    end
  end

  always_ff @(posedge clk_i or negedge w_rst_n) begin
    if (!w_rst_n) begin
      for (int c = 0; c < num_chan_p; c++) begin
        r_rd[c]    <= '0;
        r_wr[c]    <= '0;
        r_cnt[c]   <= '0;
        r_outst[c] <= '0;
      end
      r_ptr <= '0;
      r_err <= 1'b0;
    end else begin
      for (int c = 0; c < num_chan_p; c++) begin
        if (w_enq[c]) r_wr[c] <= (r_wr[c] == FW'(fifo_els_p - 1)) ? '0 : r_wr[c] + 1'b1;
        if (w_deq[c]) r_rd[c] <= (r_rd[c] == FW'(fifo_els_p - 1)) ? '0 : r_rd[c] + 1'b1;
        r_cnt[c]   <= r_cnt[c] + NW'(w_enq[c]) - NW'(w_deq[c]);
        r_outst[c] <= r_outst[c] + OW'(w_deq[c]) - OW'(w_dec[c]);
      end
      if (w_gnt_v) r_ptr <= (w_gnt == CW'(num_chan_p - 1)) ? '0 : w_gnt + 1'b1;
      if (|(w_src_v & w_src_oor)) r_err <= 1'b1;
    end
  end

`ifdef BP_MEM_CMD_ROUTER_STATS_EN
  logic [31:0] r_cmd_cnt   [num_chan_p];
  logic [31:0] r_stall_cnt [num_chan_p];
  always_ff @(posedge clk_i or negedge w_rst_n) begin
    if (!w_rst_n) begin
      for (int c = 0; c < num_chan_p; c++) begin
        r_cmd_cnt[c]   <= '0;
        r_stall_cnt[c] <= '0;
      end
    end else begin
      for (int c = 0; c < num_chan_p; c++) begin
        if (w_deq[c])             r_cmd_cnt[c]   <= r_cmd_cnt[c] + 32'd1;
        if (w_hv[c] && !w_deq[c]) r_stall_cnt[c] <= r_stall_cnt[c] + 32'd1;
      end
    end
  end
  for (genvar gc = 0; gc < num_chan_p; gc++) begin : g_stat
    assign stat_cmd_count_o[gc*32 +: 32]   = r_cmd_cnt[gc];
    assign stat_stall_count_o[gc*32 +: 32] = r_stall_cnt[gc];
  end
`endif
endmodule

// File: tb/tb_bp_mem_cmd_router.sv
// Randomized bench for bp_mem_cmd_router: queue-based reference model of FIFOs, round-robin, credits and response return.
// Message layout used here: {payload[63:44], lce_id[43:40], addr[39:0]}.
module tb_bp_mem_cmd_router;
  localparam int N  = 3;
  localparam int FE = 2;
  localparam int MO = 2;
  localparam int W  = 64;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  bp_mem_cmd_router_if #(.num_chan_p(N), .W(W)) bus ();

`ifdef BP_MEM_CMD_ROUTER_STATS_EN
  logic [N*32-1:0] stat_cmd, stat_stall;
`endif

  bp_mem_cmd_router #(
    .num_chan_p(N), .fifo_els_p(FE), .max_outstanding_p(MO), .cce_mem_msg_width_lp(W)
  ) dut (
    .clk_i(clk),
    .reset_n_i(reset_n),
    .bus(bus)
`ifdef BP_MEM_CMD_ROUTER_STATS_EN
    , .stat_cmd_count_o(stat_cmd), .stat_stall_count_o(stat_stall)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state. Targets: 0=clint, 1=io, 2=mem.
  logic [63:0] mq[N][$];
  logic [63:0] tq[3][$];
  int          outst[N];
  int          ptr;
  bit          err;
  bit          bad_pend;
  logic [63:0] bad_msg;

  int           p_cmd, p_resp, p_yumi, cls;
  int           p_rdy[3];
  logic [N-1:0] chan_mask;

  function automatic int lid(input logic [63:0] m);
    return int'(m[43:40]);
  endfunction

  function automatic int tgt_of(input logic [63:0] m);
    logic [39:0] a;
    int dev;
    a   = m[39:0];
    dev = int'((a >> 20) & 40'hF);
    if (a < 40'h80000000 && dev == 1) return 1;
    if (a < 40'h80000000 && dev == 3) return 0;
    return 2;
  endfunction

  function automatic logic [63:0] mk(input int c, input int k);
    logic [39:0] a;
    case (k)
      0:       a = {8'($urandom), 32'h80000000 | 32'($urandom)};
      1:       a = 40'h0030_0000 | 40'($urandom_range(0, 32'hFFFFF));
      2:       a = 40'h0010_0000 | 40'($urandom_range(0, 32'hFFFFF));
      default: a = 40'h0050_0000 | 40'($urandom_range(0, 32'hFFFFF));
    endcase
    return {20'($urandom), 4'(c), a};
  endfunction

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      mq[c].delete();
      outst[c] = 0;
    end
    for (int t = 0; t < 3; t++) tq[t].delete();
    ptr = 0; err = 0; bad_pend = 0;
  endtask

  task automatic drive();
    bit          v;
    logic [63:0] m;
    for (int c = 0; c < N; c++) begin
      bus.cmd_v_i[c]       = chan_mask[c] && ($urandom_range(0, 99) < p_cmd);
      bus.cmd_i[c*W +: W]  = mk(c, (cls < 0) ? int'($urandom_range(0, 3)) : cls);
      bus.resp_yumi_i[c]   = ($urandom_range(0, 99) < p_yumi);
    end
    bus.clint_cmd_ready_i = ($urandom_range(0, 99) < p_rdy[0]);
    bus.io_cmd_ready_i    = ($urandom_range(0, 99) < p_rdy[1]);
    bus.mem_cmd_ready_i   = ($urandom_range(0, 99) < p_rdy[2]);
    for (int s = 0; s < 3; s++) begin
      if (s == 2 && bad_pend) begin v = 1'b1; m = bad_msg; end
      else if (tq[s].size() > 0 && $urandom_range(0, 99) < p_resp) begin v = 1'b1; m = tq[s][0]; end
      else begin v = 1'b0; m = {$urandom, $urandom}; end
      case (s)
        0: begin bus.clint_resp_v_i = v; bus.clint_resp_i = m; end
        1: begin bus.io_resp_v_i    = v; bus.io_resp_i    = m; end
        default: begin bus.mem_resp_v_i = v; bus.mem_resp_i = m; end
      endcase
    end
  endtask

  // Compare DUT against the model for the current inputs, then advance the model one clock.
  task automatic tick_begin();
    int g, c2;
    bit rdy[3], sv[3], dv[3], dy[3], ev, sy[3];
    bit rdy_pre[N];
    logic [63:0] sm[3], dm[3];
    int sel[N];
    @(negedge clk);
    rdy = '{bus.clint_cmd_ready_i, bus.io_cmd_ready_i, bus.mem_cmd_ready_i};
    sv  = '{bus.clint_resp_v_i, bus.io_resp_v_i, bus.mem_resp_v_i};
    sm  = '{bus.clint_resp_i, bus.io_resp_i, bus.mem_resp_i};
    dv  = '{bus.clint_cmd_v_o, bus.io_cmd_v_o, bus.mem_cmd_v_o};
    dm  = '{bus.clint_cmd_o, bus.io_cmd_o, bus.mem_cmd_o};
    dy  = '{bus.clint_resp_yumi_o, bus.io_resp_yumi_o, bus.mem_resp_yumi_o};
    for (int c = 0; c < N; c++) begin
      rdy_pre[c] = (mq[c].size() < FE);
      check($sformatf("cmd_ready%0d", c), 64'(bus.cmd_ready_o[c]), 64'(rdy_pre[c]));
    end
    g = -1;
    for (int k = 0; k < N; k++) begin
      c2 = (ptr + k) % N;
      if (g < 0 && mq[c2].size() > 0 && rdy[tgt_of(mq[c2][0])] && outst[c2] < MO) g = c2;
    end
    for (int t = 0; t < 3; t++) begin
      ev = (g >= 0) && (tgt_of(mq[g][0]) == t);
      check($sformatf("tgt%0d_cmd_v", t), 64'(dv[t]), 64'(ev));
      if (ev) check($sformatf("tgt%0d_cmd", t), dm[t], mq[g][0]);
    end
    for (int c = 0; c < N; c++) begin
      sel[c] = -1;
      for (int s = 0; s < 3; s++)
        if (sel[c] < 0 && sv[s] && lid(sm[s]) == c) sel[c] = s;
      check($sformatf("resp_v%0d", c), 64'(bus.resp_v_o[c]), 64'(sel[c] >= 0));
      if (sel[c] >= 0) check($sformatf("resp%0d", c), bus.resp_o[c*W +: W], sm[sel[c]]);
    end
    for (int s = 0; s < 3; s++) begin
      sy[s] = sv[s] && (lid(sm[s]) >= N || (bus.resp_yumi_i[lid(sm[s])] && sel[lid(sm[s])] == s));
      check($sformatf("src%0d_yumi", s), 64'(dy[s]), 64'(sy[s]));
    end
    check("error", 64'(bus.error_o), 64'(err));

    for (int c = 0; c < N; c++) begin
      if (sel[c] >= 0 && bus.resp_yumi_i[c]) begin
        check($sformatf("credit_underflow%0d", c), 64'(outst[c] > 0), 64'd1);
        outst[c]--;
      end
    end
    for (int s = 0; s < 3; s++) begin
      if (sy[s]) begin
        if (s == 2 && bad_pend) bad_pend = 0;
        else void'(tq[s].pop_front());
      end
      if (sv[s] && lid(sm[s]) >= N) err = 1;
    end
    if (g >= 0) begin
      tq[tgt_of(mq[g][0])].push_back(mq[g][0]);
      void'(mq[g].pop_front());
      outst[g]++;
      ptr = (g + 1) % N;
    end
    for (int c = 0; c < N; c++)
      if (bus.cmd_v_i[c] && rdy_pre[c]) mq[c].push_back(bus.cmd_i[c*W +: W]);
  endtask

  task automatic tick_end();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    tick_begin();
    tick_end();
  endtask

  task automatic rst_pulse();
    reset_n               = 1'b0;
    bus.cmd_v_i           = '0;
    bus.resp_yumi_i       = '1;
    bus.clint_cmd_ready_i = 1'b1; bus.io_cmd_ready_i = 1'b1; bus.mem_cmd_ready_i = 1'b1;
    bus.clint_resp_v_i    = 1'b0; bus.io_resp_v_i    = 1'b0;
    bus.mem_resp_v_i      = 1'b1;
    bus.mem_resp_i        = {20'h0, 4'd0, 40'h80000000};
    repeat (2) begin
      @(negedge clk);
      check("rst_cmd_v", 64'({bus.clint_cmd_v_o, bus.io_cmd_v_o, bus.mem_cmd_v_o}), 64'd0);
      check("rst_yumi", 64'({bus.clint_resp_yumi_o, bus.io_resp_yumi_o, bus.mem_resp_yumi_o}), 64'd0);
      check("rst_resp_v", 64'(bus.resp_v_o), 64'd0);
      check("rst_error", 64'(bus.error_o), 64'd0);
      @(posedge clk);
      #1;
    end
    reset_n          = 1'b1;
    bus.mem_resp_v_i = 1'b0;
    bus.resp_yumi_i  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 64'(bus.cmd_ready_o), 64'(3'b111));
    model_reset();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.cmd_i = '0; bus.clint_resp_i = '0; bus.io_resp_i = '0;
    model_reset();
    rst_pulse();

    chan_mask = '1; p_cmd = 60; cls = -1; p_rdy = '{70, 70, 70}; p_resp = 60; p_yumi = 70;
    repeat (1500) begin drive(); tick(); end

    // Saturated mem traffic: grants rotate across channels.
    rst_pulse();
    cls = 0; p_cmd = 100; p_rdy = '{100, 100, 100}; p_resp = 100; p_yumi = 100;
    repeat (60) begin drive(); tick(); end

    // CLINT dispatch while mem is not ready.
    rst_pulse();
    chan_mask = 3'b001; cls = 1; p_rdy = '{100, 100, 0}; p_resp = 0;
    drive(); tick();
    chan_mask = '0;
    drive(); tick_begin();
    check("clint_dispatch", 64'(bus.clint_cmd_v_o), 64'd1);
    check("mem_idle", 64'(bus.mem_cmd_v_o), 64'd0);
    tick_end();

    // Credit limit on channel 1.
    rst_pulse();
    chan_mask = 3'b010; cls = 0; p_rdy = '{100, 100, 100}; p_resp = 0; p_yumi = 100;
    repeat (3) begin drive(); tick(); end
    chan_mask = '0;
    repeat (2) begin
      drive(); tick_begin();
      check("credit_hold", 64'(bus.mem_cmd_v_o), 64'd0);
      tick_end();
    end
    p_resp = 100;
    drive(); tick();
    drive(); tick_begin();
    check("credit_release", 64'(bus.mem_cmd_v_o), 64'd1);
    tick_end();

    // FIFO full with all targets stalled.
    rst_pulse();
    chan_mask = 3'b001; cls = -1; p_rdy = '{0, 0, 0}; p_resp = 0;
    repeat (2) begin drive(); tick(); end
    drive(); tick_begin();
    check("fifo_full", 64'(bus.cmd_ready_o[0]), 64'd0);
    tick_end();

    // Out-of-range lce_id on mem response.
    rst_pulse();
    chan_mask = '0; p_resp = 0;
    bad_pend = 1; bad_msg = {20'hABCDE, 4'd5, 40'h80000000};
    drive(); tick_begin();
    check("oor_yumi", 64'(bus.mem_resp_yumi_o), 64'd1);
    check("oor_no_resp", 64'(bus.resp_v_o), 64'd0);
    tick_end();
    drive(); tick_begin();
    check("err_sticky", 64'(bus.error_o), 64'd1);
    tick_end();
    chan_mask = '1; p_cmd = 60; p_rdy = '{70, 70, 70}; p_resp = 60; p_yumi = 70;
    repeat (50) begin drive(); tick(); end
    rst_pulse();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
